// File: rtl/apb_irq_controller.sv
// apb_irq_controller
// APB slave aggregating up to 32 interrupt sources into one registered irq.
// Each source is level- or rising-edge-triggered (EDGE_MASK), has an enable
// bit, and edge sources hold a write-1-to-clear pending bit.
//
// Register map (byte offsets, paddr[1:0] ignored):
//   0x00 RAW      RO   current irq_in
//   0x04 PENDING  RO/W1C (W1C affects edge sources only)
//   0x08 ENABLE   RW
//   0x0C STATUS   RO   PENDING & ENABLE
//   0x10 FORCE    WO   only when APB_IRQ_FORCE_EN is defined; sets PENDING
//                      for edge sources, reads 0
// Any other offset (including 0x10 without APB_IRQ_FORCE_EN) reads 0,
// ignores writes and answers with pslverr.
//
// Every access takes exactly one wait state: pready, prdata and pslverr are
// registered on the edge that ends the first access cycle.

module apb_irq_controller #(
    parameter int unsigned NUM_IRQS  = 8,
    parameter logic [31:0] EDGE_MASK = 32'h0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [9:0]          paddr,
    input  logic [31:0]         pwdata,
    output logic                pready,
    output logic [31:0]         prdata,
    output logic                pslverr,
    input  logic [NUM_IRQS-1:0] irq_in,
    output logic                irq
);

    // Word offsets of the mapped registers (paddr[9:2]).
    typedef enum logic [7:0] {
        OFF_RAW     = 8'h00,
        OFF_PENDING = 8'h01,
        OFF_ENABLE  = 8'h02,
        OFF_STATUS  = 8'h03,
        OFF_FORCE   = 8'h04
    } reg_off_t;

    // Bits that correspond to real sources; everything above reads 0.
    localparam logic [31:0] VALID_MASK =
        (NUM_IRQS >= 32) ? 32'hFFFF_FFFF : ((32'd1 << NUM_IRQS) - 32'd1);
    localparam logic [31:0] EDGE_BITS  = EDGE_MASK & VALID_MASK;
    localparam logic [31:0] LEVEL_BITS = VALID_MASK & ~EDGE_BITS;

    logic [31:0] raw;        // irq_in zero-extended to 32 bits
    logic [31:0] prev;       // irq_in from the previous cycle
    logic [31:0] rise;       // rising edges on edge-triggered sources
    logic [31:0] edge_pend;  // latched pending bits of edge sources
    logic [31:0] enable_q;   // ENABLE register
    logic [31:0] pending;    // architectural PENDING value
    logic [31:0] status;     // PENDING & ENABLE
    logic [31:0] set_bits;   // pending bits being set this cycle
    logic [31:0] w1c_clr;    // pending bits being cleared this cycle
    logic [31:0] rd_value;   // read mux output
    logic [7:0]  offset;     // word offset of the current access
    logic        access;     // first cycle of an access phase
    logic        wr_access;  // committing write
    logic        rd_access;  // completing read
    logic        addr_hit;   // offset maps to a register

    // paddr[1:0] carry no information for word-wide registers.
    logic unused_addr_bits;
    assign unused_addr_bits = ^paddr[1:0];

    assign offset    = paddr[9:2];
    assign access    = psel & penable & ~pready;
    assign wr_access = access & pwrite;
    assign rd_access = access & ~pwrite;

    // Zero-extend the source vector so all registers are handled at 32 bits.
    always_comb begin
        raw = '0;
        raw[NUM_IRQS-1:0] = irq_in;
    end

    // Edge detection and the architectural view of pending/status.
    always_comb begin
        rise    = raw & ~prev & EDGE_BITS;
        pending = (edge_pend & EDGE_BITS) | (raw & LEVEL_BITS);
        status  = pending & enable_q;
    end

    // Pending set/clear requests from hardware edges, FORCE and W1C writes.
    always_comb begin
        w1c_clr = '0;
        if (wr_access && (offset == OFF_PENDING)) begin
            w1c_clr = pwdata & EDGE_BITS;
        end
`ifdef APB_IRQ_FORCE_EN
        set_bits = rise;
        if (wr_access && (offset == OFF_FORCE)) begin
            set_bits = rise | (pwdata & EDGE_BITS);
        end
`else
        set_bits = rise;
`endif
    end

    // Register read mux and address decode; unmapped offsets read as 0.
    always_comb begin
        rd_value = '0;
        addr_hit = 1'b1;
        case (offset)
            OFF_RAW:     rd_value = raw;
            OFF_PENDING: rd_value = pending;
            OFF_ENABLE:  rd_value = enable_q;
            OFF_STATUS:  rd_value = status;
`ifdef APB_IRQ_FORCE_EN
            OFF_FORCE:   rd_value = '0;
`endif
            default:     addr_hit = 1'b0;
        endcase
    end

    // Previous-input register; also loaded during reset so a source that is
    // already high when reset releases does not look like a fresh edge.
    always_ff @(posedge clk) begin
        prev <= raw;
    end

    // Edge pending bits: a set in the same cycle as a W1C wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            edge_pend <= '0;
        end else begin
            edge_pend <= ((edge_pend & ~w1c_clr) | set_bits) & EDGE_BITS;
        end
    end

    // ENABLE register; bits above NUM_IRQS are never stored.
    always_ff @(posedge clk) begin
        if (rst) begin
            enable_q <= '0;
        end else if (wr_access && (offset == OFF_ENABLE)) begin
            enable_q <= pwdata & VALID_MASK;
        end
    end

    // APB response: one wait state, prdata held between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            pready  <= 1'b0;
            prdata  <= '0;
            pslverr <= 1'b0;
        end else begin
            pready  <= access;
            pslverr <= access & ~addr_hit;
            if (rd_access) begin
                prdata <= rd_value;
            end
        end
    end

    // Registered aggregate interrupt line.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq <= 1'b0;
        end else begin
            irq <= |status;
        end
    end

endmodule

// File: tb/tb_apb_irq_controller.sv
// Directed self-checking bench for apb_irq_controller (NUM_IRQS=8,
// EDGE_MASK=0x0F: sources 0-3 edge-triggered, 4-7 level-triggered).
// FORCE checks depend on APB_IRQ_FORCE_EN.

module tb_apb_irq_controller;

    logic        clk;
    logic        rst;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [9:0]  paddr;
    logic [31:0] pwdata;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
    logic [7:0]  irq_in;
    logic        irq;

    int n_checks;
    int n_fail;

    apb_irq_controller #(
        .NUM_IRQS (8),
        .EDGE_MASK(32'h0000_000F)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .psel   (psel),
        .penable(penable),
        .pwrite (pwrite),
        .paddr  (paddr),
        .pwdata (pwdata),
        .pready (pready),
        .prdata (prdata),
        .pslverr(pslverr),
        .irq_in (irq_in),
        .irq    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Full APB transfer; w counts cycles from penable to pready (99 on timeout).
    task automatic apb_xfer(input logic wr, input logic [9:0] a, input logic [31:0] wd,
                            output logic [31:0] rd, output logic err, output int w);
        logic done;
        @(negedge clk);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a;
        pwdata  = wd;
        @(negedge clk);
        penable = 1'b1;
        w    = 0;
        rd   = '0;
        err  = 1'b0;
        done = 1'b0;
        while (!done && (w < 8)) begin
            @(posedge clk);
            #1;
            w++;
            if (pready) begin
                rd   = prdata;
                err  = pslverr;
                done = 1'b1;
            end
        end
        if (!done) w = 99;
        @(negedge clk);
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
    endtask

    logic [31:0] rd;
    logic        err;
    int          w;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        psel     = 1'b0;
        penable  = 1'b0;
        pwrite   = 1'b0;
        paddr    = '0;
        pwdata   = '0;
        irq_in   = 8'h01;

        // Reset with edge source 0 already high.
        repeat (3) @(posedge clk);
        #1;
        check("rst_pready", {31'b0, pready}, 32'h0);
        check("rst_prdata", prdata, 32'h0);
        check("rst_pslverr", {31'b0, pslverr}, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_irq", {31'b0, irq}, 32'h0);
        apb_xfer(1'b0, 10'h004, '0, rd, err, w);
        check("post_rst_pending", rd, 32'h0);
        check("post_rst_waits", w, 1);
        apb_xfer(1'b0, 10'h008, '0, rd, err, w);
        check("post_rst_enable", rd, 32'h0);
        apb_xfer(1'b0, 10'h000, '0, rd, err, w);
        check("raw_read", rd, 32'h01);
        check("raw_read_err", {31'b0, err}, 32'h0);
        irq_in = 8'h00;

        // ENABLE ignores bits above NUM_IRQS.
        apb_xfer(1'b1, 10'h008, 32'hFFFF_FFFF, rd, err, w);
        check("wr_enable_err", {31'b0, err}, 32'h0);
        apb_xfer(1'b0, 10'h008, '0, rd, err, w);
        check("enable_mask", rd, 32'h0000_00FF);
        apb_xfer(1'b1, 10'h008, 32'h0000_000F, rd, err, w);

        // One-cycle pulse on edge source 2.
        @(negedge clk);
        irq_in = 8'h04;
        @(posedge clk);
        #1;
        check("edge2_irq_E", {31'b0, irq}, 32'h0);
        @(negedge clk);
        irq_in = 8'h00;
        @(posedge clk);
        #1;
        check("edge2_irq_E1", {31'b0, irq}, 32'h1);
        apb_xfer(1'b0, 10'h004, '0, rd, err, w);
        check("edge2_pending", rd, 32'h04);
        apb_xfer(1'b0, 10'h00C, '0, rd, err, w);
        check("edge2_status", rd, 32'h04);
        apb_xfer(1'b1, 10'h004, 32'h04, rd, err, w);
        check("w1c2_irq_commit", {31'b0, irq}, 32'h1);
        @(posedge clk);
        #1;
        check("w1c2_irq_after", {31'b0, irq}, 32'h0);
        apb_xfer(1'b0, 10'h004, '0, rd, err, w);
        check("w1c2_pending", rd, 32'h0);

        // Level source 5: W1C has no effect while the input is high.
        apb_xfer(1'b1, 10'h008, 32'h0000_002F, rd, err, w);
        @(negedge clk);
        irq_in = 8'h20;
        @(posedge clk);
        #1;
        check("lvl5_irq_rise", {31'b0, irq}, 32'h1);
        apb_xfer(1'b1, 10'h004, 32'h20, rd, err, w);
        apb_xfer(1'b0, 10'h004, '0, rd, err, w);
        check("lvl5_w1c_pending", rd, 32'h20);
        check("lvl5_w1c_irq", {31'b0, irq}, 32'h1);
        @(negedge clk);
        irq_in = 8'h00;
        @(posedge clk);
        #1;
        check("lvl5_irq_fall", {31'b0, irq}, 32'h0);
        apb_xfer(1'b0, 10'h004, '0, rd, err, w);
        check("lvl5_pending_low", rd, 32'h0);

        // Source 1: edge arrives on the same edge the W1C commits.
        @(negedge clk);
        irq_in = 8'h02;
        @(negedge clk);
        irq_in = 8'h00;
        @(posedge clk);
        #1;
        check("src1_irq_set", {31'b0, irq}, 32'h1);
        @(negedge clk);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 10'h004;
        pwdata  = 32'h02;
        @(negedge clk);
        penable = 1'b1;
        irq_in  = 8'h02;
        @(posedge clk);
        #1;
        check("simul_pready", {31'b0, pready}, 32'h1);
        @(negedge clk);
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        irq_in  = 8'h00;
        @(posedge clk);
        #1;
        check("simul_irq", {31'b0, irq}, 32'h1);
        apb_xfer(1'b0, 10'h004, '0, rd, err, w);
        check("simul_pending", rd, 32'h02);
        apb_xfer(1'b1, 10'h004, 32'h02, rd, err, w);
        @(posedge clk);
        #1;
        check("src1_clr_irq", {31'b0, irq}, 32'h0);

        // prdata holds and pready/pslverr drop after a read.
        apb_xfer(1'b0, 10'h008, '0, rd, err, w);
        check("enable_2f", rd, 32'h2F);
        @(posedge clk);
        #1;
        check("hold_prdata", prdata, 32'h2F);
        check("hold_pready", {31'b0, pready}, 32'h0);
        check("hold_pslverr", {31'b0, pslverr}, 32'h0);

        // Unmapped accesses.
        apb_xfer(1'b0, 10'h3FC, '0, rd, err, w);
        check("unmap_prdata", rd, 32'h0);
        check("unmap_pslverr", {31'b0, err}, 32'h1);
        check("unmap_waits", w, 1);
        apb_xfer(1'b1, 10'h008, 32'h0, rd, err, w);
        apb_xfer(1'b1, 10'h3F0, 32'hFF, rd, err, w);
        check("unmap_wr_err", {31'b0, err}, 32'h1);
        apb_xfer(1'b0, 10'h008, '0, rd, err, w);
        check("unmap_wr_noeffect", rd, 32'h0);
        apb_xfer(1'b0, 10'h010, '0, rd, err, w);
        check("force_rd_prdata", rd, 32'h0);
`ifdef APB_IRQ_FORCE_EN
        check("force_rd_pslverr", {31'b0, err}, 32'h0);
        apb_xfer(1'b1, 10'h008, 32'hFF, rd, err, w);
        apb_xfer(1'b1, 10'h010, 32'h31, rd, err, w);
        check("force_wr_err", {31'b0, err}, 32'h0);
        apb_xfer(1'b0, 10'h004, '0, rd, err, w);
        check("force_pending", rd, 32'h01);
        check("force_irq", {31'b0, irq}, 32'h1);
`else
        check("force_rd_pslverr", {31'b0, err}, 32'h1);
        apb_xfer(1'b1, 10'h008, 32'hFF, rd, err, w);
        apb_xfer(1'b1, 10'h010, 32'h31, rd, err, w);
        check("force_wr_err", {31'b0, err}, 32'h1);
        apb_xfer(1'b0, 10'h004, '0, rd, err, w);
        check("force_pending", rd, 32'h0);
        check("force_irq", {31'b0, irq}, 32'h0);
`endif

        // Reset in the middle of a transfer clears everything.
        @(negedge clk);
        irq_in = 8'h01;
        @(negedge clk);
        irq_in = 8'h00;
        @(posedge clk);
        #1;
        check("pre_rst_irq", {31'b0, irq}, 32'h1);
        @(negedge clk);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 10'h008;
        @(negedge clk);
        penable = 1'b1;
        rst     = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_pready", {31'b0, pready}, 32'h0);
        check("midrst_irq", {31'b0, irq}, 32'h0);
        @(negedge clk);
        rst     = 1'b0;
        psel    = 1'b0;
        penable = 1'b0;
        apb_xfer(1'b0, 10'h008, '0, rd, err, w);
        check("midrst_enable", rd, 32'h0);
        apb_xfer(1'b0, 10'h004, '0, rd, err, w);
        check("midrst_pending", rd, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_irq_controller.md
# apb_irq_controller

Parametrised APB interrupt controller that replaces the hard-wired OR of Ethernet RX-ready flags in the management subsystem. It aggregates up to 32 sources, each level- or edge-triggered, with per-source enable and write-1-to-clear pending bits, and drives a single registered `irq` line to the management MCU. It sits on one port of the small-device APB bridge (1 kB window) behind an APB register slice.

## Interface
- `NUM_IRQS`, 8: number of interrupt sources, 1..32.
- `EDGE_MASK`, 32'h0: bit i set makes source i rising-edge-triggered; clear makes it level-triggered.
- `clk`  in  1  system clock (APB pclk domain). Only clock in the block.
- `rst`  in  1  reset: synchronous, active-high.
- `psel`, `penable`, `pwrite`  in  1 each  APB control.
- `paddr`  in  10  byte address; bits [1:0] ignored.
- `pwdata`  in  32  write data.
- `pready`  out  1  access complete.
- `prdata`  out  32  read data.
- `pslverr`  out  1  error on unmapped address.
- `irq_in`  in  NUM_IRQS  source inputs, synchronous to `clk`.
- `irq`  out  1  aggregated interrupt to MCU.

## Operation
- Register map (32-bit; bits at or above NUM_IRQS read 0 and ignore writes):
  - 0x00 RAW, RO: current `irq_in`.
  - 0x04 PENDING, RO/W1C. Edge source: set on rising edge of `irq_in`, cleared by writing 1. Level source: equals `irq_in`; W1C has no effect.
  - 0x08 ENABLE, RW, reset 0.
  - 0x0C STATUS, RO: PENDING & ENABLE.
  - 0x10 FORCE, WO (reads 0), only with the config macro: writing 1 sets PENDING for edge sources; level bits ignored.
- Unmapped offset (including 0x10 without the macro): read returns 0, write ignored, `pslverr`=1.
- Edge detect: `prev` register, `edge = irq_in & ~prev`. During `rst`, `prev <= irq_in`, so a source already high at reset release does not produce an edge.
- Simultaneous set and clear on the same pending bit (edge or FORCE in the same cycle as W1C): set wins, the bit stays 1.
- `irq` is registered: `irq <= |(PENDING & ENABLE)`.
- Reset values: PENDING 0, ENABLE 0, `irq` 0, `pready` 0, `prdata` 0, `pslverr` 0.
- Reset mid-transfer: all state is cleared and `pready` drops to 0. The requester must restart the transfer.

## Timing
- One wait state per transfer.
  - Cycle N: `psel & penable & !pready`.
  - Edge ending cycle N: `pready`=1, with `prdata` and `pslverr` registered, valid during cycle N+1.
  - `pready` returns to 0 after one cycle.
- Write commit: registers update on the same edge that sets `pready`. A read issued afterwards sees the new value.
- `irq` latency:
  - Edge source: rising edge of `irq_in` sampled at edge E; PENDING is set at E and `irq` rises at E+1.
  - Level source: `irq` follows `irq_in` (when enabled) with 1 cycle delay.
  - W1C: `irq` falls 1 cycle after the committing edge, provided nothing else is pending.
- `prdata` holds its last value when not completing a read. `pslverr` is 0 except in the `pready` cycle of an error access.

## Configuration
- `APB_IRQ_FORCE_EN` defined: the FORCE register at 0x10 exists, giving software-triggered interrupts on edge sources.
- Not defined: FORCE logic is absent, and 0x10 behaves as unmapped (`pslverr`=1, no side effects).

## Test plan
- Reset with `irq_in`=8'h01, NUM_IRQS=8, EDGE_MASK=8'h01 -> after reset PENDING=0, `irq`=0, and no spurious edge is latched.
- EDGE_MASK=8'h0F, ENABLE=0x0F, 1-cycle pulse on `irq_in[2]` -> PENDING=0x04 and `irq`=1 one cycle later. Write 0x04 to 0x04 -> PENDING=0, `irq` falls next cycle.
- Level source 5 enabled, `irq_in[5]` held high -> W1C 0x20 leaves PENDING[5]=1. Drop `irq_in[5]` -> PENDING[5]=0 and `irq`=0 one cycle later.
- Edge on source 1 in the same cycle as the W1C of bit 1 committing -> PENDING[1] stays 1 and `irq` stays 1.
- Read 0x3FC -> `prdata`=0, `pslverr`=1, `pready` after exactly one wait state. Read 0x10 gives `pslverr`=1 without the macro and 0 with it.
- With `APB_IRQ_FORCE_EN`: write 0x03 to FORCE, EDGE_MASK=8'h01, ENABLE=0xFF -> PENDING=0x01 (level bit 1 ignored) and `irq`=1.
